// File: rtl/bit_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module      : bit_pattern_gen
//  Description : Generates a word containing N contiguous low-order one bits,
//                where N = min(count_in, WIDTH). The ones are shifted in one
//                per clock. Start (s) is a level handshake: it is held high
//                until done is observed. It must then drop for at least one
//                idle cycle before another fill can begin.
//
//  Ports       : clk       - rising-edge clock
//                reset     - synchronous, active-high reset
//                s         - start request (level, held until done)
//                count_in  - number of one bits requested (saturates at WIDTH)
//                result    - generated word (registered)
//                busy      - high while the fill is in progress
//                done      - high while result is final
//
//  Revision    : 1.0 - initial release
// ============================================================================
module bit_pattern_gen #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s,
  input  logic [CW-1:0]    count_in,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_idle = 2'd0,
    S_fill = 2'd1,
    S_done = 2'd2
  } state_t;

  localparam logic [CW-1:0] c_width = CW'(WIDTH);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] w_result_nxt;
  logic [CW-1:0]    w_cnt_sat;

  // Requests above WIDTH clamp to WIDTH so the count can never wrap.
  always_comb begin
    w_cnt_sat = (count_in > c_width) ? c_width : count_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_idle;
      r_cnt    <= '0;
      r_result <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_result <= w_result_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_result_nxt = r_result;
    case (r_state)
      // Count is captured every cycle that s is low. The value seen on the
      // final low cycle is the one that gets used.
      S_idle: begin
        if (!s) begin
          w_cnt_nxt    = w_cnt_sat;
          w_result_nxt = '0;
        end else begin
          w_state_nxt  = S_fill;
        end
      end
      // One extra cycle is spent here with cnt == 0 before moving to done.
      // As a result, a zero-length request still shows busy for one cycle.
      S_fill: begin
        if (r_cnt != '0) begin
          w_result_nxt = {r_result[WIDTH-2:0], 1'b1};
          w_cnt_nxt    = r_cnt - CW'(1);
        end else begin
          w_state_nxt  = S_done;
        end
      end
      S_done: begin
        if (!s) begin
          w_state_nxt = S_idle;
        end
      end
      default: begin
        w_state_nxt = S_idle;
      end
    endcase
  end

  assign result = r_result;
  assign busy   = (r_state == S_fill);
  assign done   = (r_state == S_done);

endmodule
`default_nettype wire

// File: tb/tb_bit_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bit_pattern_gen
//  Description : Scoreboard bench for bit_pattern_gen. The driver pushes the
//                expected word and fill length whenever it starts a run. A
//                monitor pops an entry and compares it at each rising edge
//                of done.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bit_pattern_gen;

  localparam int WIDTH = 8;
  localparam int CW    = $clog2(WIDTH + 1);

  typedef struct {
    logic [WIDTH-1:0] word;
    int               fill_len;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             s;
  logic [CW-1:0]    count_in;
  logic [WIDTH-1:0] result;
  logic             busy;
  logic             done;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  bit_pattern_gen #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .s        (s),
    .count_in (count_in),
    .result   (result),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Reference model: a request of n gives min(n, WIDTH) low ones.
  // The fill phase lasts one cycle longer than the number of ones.
  function automatic exp_t model(input int n);
    exp_t e;
    int   m;
    m          = (n > WIDTH) ? WIDTH : n;
    e.word     = WIDTH'((64'd1 << m) - 64'd1);
    e.fill_len = m + 1;
    return e;
  endfunction

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- monitor ----------------
  int               busy_len  = 0;
  logic             prev_done = 1'b0;
  logic [WIDTH-1:0] held;

  always @(negedge clk) begin
    if (reset) begin
      busy_len  = 0;
      prev_done = 1'b0;
    end else begin
      if (busy && done) check("busy_done_exclusive", 1, 0);
      if (busy) busy_len++;
      if (done && !prev_done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("result", int'(result), int'(e.word));
          check("busy_len", busy_len, e.fill_len);
        end
        busy_len = 0;
        held     = result;
      end else if (done && prev_done) begin
        check("result_hold", int'(result), int'(held));
      end
      prev_done = done;
    end
  end

  // ---------------- driver ----------------
  task automatic wait_done();
    int k;
    for (k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) break;
    end
    if (k == 40) check("done_timeout", 0, 1);
  endtask

  // Precondition: DUT will be idle at the next edge and s is low.
  task automatic start(input int cin);
    count_in = CW'(cin);
    @(posedge clk); #1;
    exp_q.push_back(model(cin));
    s = 1'b1;
  endtask

  task automatic finish_run(input int hold);
    wait_done();
    repeat (hold) @(posedge clk);
    #1 s = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic run(input int cin, input int hold);
    start(cin);
    finish_run(hold);
  endtask

  initial begin
    reset    = 1'b1;
    s        = 1'b0;
    count_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_result", int'(result), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);

    // s high on the first cycle out of reset: cnt is 0, so the result is 0.
    @(posedge clk); #1;
    reset = 1'b0;
    s     = 1'b1;
    exp_q.push_back(model(0));
    finish_run(1);

    run(3, 3);
    run(0, 1);
    run(8, 2);
    run(15, 1);

    // count_in and s change mid-fill: neither may disturb the run.
    start(5);
    @(negedge clk); @(negedge clk);
    count_in = CW'(1);
    s        = 1'b0;
    wait_done();
    @(negedge clk);
    check("done_one_cycle", int'(done), 0);
    check("idle_after_done", int'(busy), 0);
    @(posedge clk); #1;

    // Reset on the third fill cycle discards the partial word.
    count_in = CW'(6);
    @(posedge clk); #1;
    s = 1'b1;
    @(posedge clk); #1;          // fill cycle 1
    @(posedge clk); #1;          // fill cycle 2
    @(posedge clk); #1;          // fill cycle 3
    reset = 1'b1;
    s     = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("midfill_reset_result", int'(result), 0);
    check("midfill_reset_busy", int'(busy), 0);
    check("midfill_reset_done", int'(done), 0);
    run(2, 1);

    // Back-to-back runs with a minimal gap between them.
    run(4, 0);
    run(2, 0);

    // Randomized runs.
    for (int i = 0; i < 12; i++) begin
      run(int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
